gravador_instrucoes: RTL

//   Program loader: the write side of the instruction memory. Takes a byte stream over a

---
 rtl/gravador_instrucoes.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gravador_instrucoes.sv
// Program loader: packs a valid/ready byte stream little-endian into 32-bit words
// and writes them to consecutive instruction-memory addresses while holding the CPU off.
module gravador_instrucoes #(
    parameter int PROFUNDIDADE = 9,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inicio,
    input  logic [ADDR_W:0]   total_palavras,
    input  logic [7:0]        byte_in,
    input  logic              byte_valido,
    output logic              byte_pronto,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic [31:0]       mem_dado,
    output logic              ocupado,
    output logic              concluido,
    output logic              erro
);
    typedef enum logic [1:0] {OCIOSO, RECEBE, GRAVA, CONCLUIDO} estado_t;

    localparam logic [ADDR_W:0] MAX_PALAVRAS = (ADDR_W+1)'(PROFUNDIDADE);

    estado_t           r_estado;
    logic [ADDR_W:0]   r_total;
    logic [ADDR_W:0]   r_palavra;
    logic [1:0]        r_byte;
    logic [31:0]       r_staging;
    logic              r_pronto;
    logic              r_we;
    logic [ADDR_W-1:0] r_endereco;
    logic [31:0]       r_dado;
    logic              r_ocupado;
    logic              r_concluido;
    logic              r_erro;

    logic              w_aceita;
    logic              w_total_ok;
    logic [ADDR_W:0]   w_prox_palavra;

    assign w_aceita       = byte_valido & r_pronto;
    assign w_total_ok     = (total_palavras != '0) && (total_palavras <= MAX_PALAVRAS);
    assign w_prox_palavra = r_palavra + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_total     <= '0;
            r_palavra   <= '0;
            r_byte      <= '0;
            r_staging   <= '0;
            r_pronto    <= 1'b0;
            r_we        <= 1'b0;
            r_endereco  <= '0;
            r_dado      <= '0;
            r_ocupado   <= 1'b0;
            r_concluido <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO, CONCLUIDO: begin
                    if (inicio) begin
                        r_concluido <= 1'b0;
                        if (!w_total_ok) begin
                            r_erro   <= 1'b1;
                            r_estado <= OCIOSO;
                        end else begin
                            r_erro    <= 1'b0;
                            r_total   <= total_palavras;
                            r_palavra <= '0;
                            r_byte    <= '0;
                            r_staging <= '0;
                            r_ocupado <= 1'b1;
                            r_pronto  <= 1'b1;
                            r_estado  <= RECEBE;
                        end
                    end
                end
                RECEBE: begin
                    if (w_aceita) begin
                        if (r_byte == 2'd3) begin
                            // Fourth byte bypasses staging so the write launches on this edge
                            r_dado     <= {byte_in, r_staging[23:0]};
                            r_endereco <= r_palavra[ADDR_W-1:0];
                            r_we       <= 1'b1;
                            r_pronto   <= 1'b0;
                            r_byte     <= '0;
                            r_staging  <= '0;
                            r_estado   <= GRAVA;
                        end else begin
                            r_staging[{r_byte, 3'b000} +: 8] <= byte_in;
                            r_byte <= r_byte + 1'b1;
                        end
                    end
                end
                GRAVA: begin
                    r_we      <= 1'b0;
                    r_palavra <= w_prox_palavra;
                    if (w_prox_palavra == r_total) begin
                        r_ocupado   <= 1'b0;
                        r_concluido <= 1'b1;
                        r_estado    <= CONCLUIDO;
                    end else begin
                        r_pronto <= 1'b1;
                        r_estado <= RECEBE;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign byte_pronto  = r_pronto;
    assign mem_we       = r_we;
    assign mem_endereco = r_endereco;
    assign mem_dado     = r_dado;
    assign ocupado      = r_ocupado;
    assign concluido    = r_concluido;
    assign erro         = r_erro;
endmodule
